// File: rtl/pwm_rgb_servo_top.sv
// PWM demo block: shared PWM time base, triangle ramp animator, three RGB channels and a servo.
// Build option PWM_SERVO_EN: when defined the servo frame/pulse logic is built, otherwise servo_out is 0.

module pwm_chan #(
  parameter int RES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RES-1:0] cnt,
  input  logic [RES:0]   duty,
  output logic           pwm
);
  // duty is one bit wider than the counter so 2^RES means "always on"
  always_ff @(posedge clk) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= ({1'b0, cnt} < duty);
  end
endmodule

module pwm_rgb_servo_top #(
  parameter int          resolution   = 8,
  parameter int          grad_thresh  = 2000,
  parameter logic [31:0] dvsr         = 32'd48,
  parameter int          SERVO_PERIOD = 2_500_000,
  parameter int          SERVO_MIN    = 125_000,
  parameter int          SERVO_STEP   = 488
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [2:0] rgb,
  output logic       servo_out
);
  localparam int NUM_CH = 3;
  localparam logic [resolution-1:0] RMAX = '1;
  localparam logic [resolution:0]   DMAX = {1'b1, {resolution{1'b0}}};

  typedef enum logic [2:0] {M_OFF, M_RED, M_GREEN, M_WHEEL, M_SERVO} mode_t;
  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} hue_t;

  mode_t mode, mode_q;
  hue_t  hue_q, hue_d;
  logic  mode_chg, tick, strobe, wrap, dir_up;
  logic [31:0] psc_cnt, step_cnt;
  logic [resolution-1:0] pwm_cnt, r;
  logic [resolution:0]   rz, rinv;
  logic [NUM_CH-1:0][resolution:0] duty;

  always_comb begin
    mode = M_OFF;
    if      (sw[0]) mode = M_RED;
    else if (sw[1]) mode = M_GREEN;
    else if (sw[2]) mode = M_WHEEL;
    else if (sw[3]) mode = M_SERVO;
  end

  assign mode_chg = (mode != mode_q);
  assign tick     = (dvsr <= 32'd1) || (psc_cnt == dvsr - 32'd1);
  assign strobe   = (step_cnt == 32'(grad_thresh - 1));
  assign wrap     = strobe && (dir_up ? (r == RMAX) : (r == '0));

  // Prescaler and PWM counter deliberately ignore mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt <= '0;
      pwm_cnt <= '0;
      mode_q  <= M_OFF;
    end else begin
      psc_cnt <= tick ? '0 : psc_cnt + 32'd1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      mode_q  <= mode;
    end
  end

  // Triangle ramp: turn around at the ends without dwelling.
  always_ff @(posedge clk) begin
    if (rst || mode_chg) begin
      step_cnt <= '0;
      r        <= '0;
      dir_up   <= 1'b1;
      hue_q    <= P0;
    end else begin
      step_cnt <= strobe ? '0 : step_cnt + 32'd1;
      hue_q    <= hue_d;
      if (strobe) begin
        if (dir_up) begin
          if (r == RMAX) begin r <= r - 1'b1; dir_up <= 1'b0; end
          else           r <= r + 1'b1;
        end else begin
          if (r == '0)   begin r <= r + 1'b1; dir_up <= 1'b1; end
          else           r <= r - 1'b1;
        end
      end
    end
  end

  always_comb begin
    hue_d = hue_q;
    if (wrap) begin
      case (hue_q)
        P0:      hue_d = P1;
        P1:      hue_d = P2;
        P2:      hue_d = P3;
        P3:      hue_d = P4;
        P4:      hue_d = P5;
        default: hue_d = P0;
      endcase
    end
  end

  assign rz   = {1'b0, r};
  assign rinv = DMAX - rz;

  // duty[0]=red, duty[1]=green, duty[2]=blue
  always_comb begin
    duty = '0;
    case (mode)
      M_RED:   duty[0] = rz;
      M_GREEN: duty[1] = rz;
      M_WHEEL: begin
        case (hue_q)
          P0:      begin duty[0] = DMAX; duty[1] = rz;   end
          P1:      begin duty[0] = rinv; duty[1] = DMAX; end
          P2:      begin duty[1] = DMAX; duty[2] = rz;   end
          P3:      begin duty[1] = rinv; duty[2] = DMAX; end
          P4:      begin duty[0] = rz;   duty[2] = DMAX; end
          default: begin duty[0] = DMAX; duty[2] = rinv; end
        endcase
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_chan #(.RES(resolution)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .cnt  (pwm_cnt),
      .duty (duty[i]),
      .pwm  (rgb[i])
    );
  end

`ifdef PWM_SERVO_EN
  logic [31:0] frame_cnt, width_q, width_cur;
  logic        en_q, en_cur, frame_start;

  // Pulse width and enable are frozen at frame start; the frame restarts on
  // mode entry so the first servo pulse always uses position 0.
  assign frame_start = (frame_cnt == '0);
  assign width_cur   = frame_start ? 32'(SERVO_MIN) + 32'(r) * 32'(SERVO_STEP) : width_q;
  assign en_cur      = frame_start ? (mode == M_SERVO) : en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      width_q   <= '0;
      en_q      <= 1'b0;
      servo_out <= 1'b0;
    end else begin
      frame_cnt <= (mode_chg || frame_cnt == 32'(SERVO_PERIOD - 1)) ? '0 : frame_cnt + 32'd1;
      width_q   <= width_cur;
      en_q      <= en_cur;
      servo_out <= (mode == M_SERVO) && en_cur && (frame_cnt < width_cur);
    end
  end
`else
  assign servo_out = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_rgb_servo_top.sv
// Scoreboard bench for pwm_rgb_servo_top with shrunk timing parameters; servo checks follow PWM_SERVO_EN.

module tb_pwm_rgb_servo_top;
  localparam int RES   = 4;
  localparam int M     = 1 << RES;
  localparam int RMAX  = M - 1;
  localparam int DV    = 3;
  localparam int GT    = 5;
  localparam int SP    = 170;
  localparam int SMIN  = 20;
  localparam int SSTEP = 3;

  logic       clk, rst;
  logic [3:0] sw;
  logic [2:0] rgb;
  logic       servo_out;

  int vectors = 0;
  int miscompares = 0;

  // model state: edges since reset (t_m), edges since mode entry (c_m), current mode
  int t_m = 0, c_m = 0, mode_m = 0;
  logic [2:0] exp_rgb[$];
  logic       exp_srv[$];

  pwm_rgb_servo_top #(
    .resolution   (RES),
    .grad_thresh  (GT),
    .dvsr         (32'(DV)),
    .SERVO_PERIOD (SP),
    .SERVO_MIN    (SMIN),
    .SERVO_STEP   (SSTEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .rgb       (rgb),
    .servo_out (servo_out)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  function automatic int dec(logic [3:0] s);
    if (s[0]) return 1;
    if (s[1]) return 2;
    if (s[2]) return 3;
    if (s[3]) return 4;
    return 0;
  endfunction

  // ramp value after n strobes: triangle of period 2*RMAX
  function automatic int tri_r(int n);
    int k;
    k = n % (2 * RMAX);
    return (k <= RMAX) ? k : 2 * RMAX - k;
  endfunction

  // hue phase after n strobes: one advance per turnaround (every RMAX strobes past the first)
  function automatic int hue(int n);
    return (n == 0) ? 0 : ((n - 1) / RMAX) % 6;
  endfunction

  task automatic step();
    int md, n, rv, pw;
    int d[3];
    logic [2:0] er;
    logic es;
    bit chk;
    md = dec(sw);
    chk = 1'b1;
    er = '0;
    es = 1'b0;
    if (!rst) begin
      if (md != mode_m) chk = 1'b0;
      else begin
        n  = c_m / GT;
        rv = tri_r(n);
        pw = (t_m / DV) % M;
        d  = '{0, 0, 0};
        case (md)
          1: d[0] = rv;
          2: d[1] = rv;
          3: case (hue(n))
               0: begin d[0] = M;      d[1] = rv;     end
               1: begin d[0] = M - rv; d[1] = M;      end
               2: begin d[1] = M;      d[2] = rv;     end
               3: begin d[1] = M - rv; d[2] = M;      end
               4: begin d[0] = rv;     d[2] = M;      end
               default: begin d[0] = M; d[2] = M - rv; end
             endcase
          default: ;
        endcase
        for (int i = 0; i < 3; i++) er[i] = (pw < d[i]);
`ifdef PWM_SERVO_EN
        if (md == 4) begin
          int f, fs;
          f  = c_m % SP;
          fs = c_m - f;
          es = (f < SMIN + tri_r(fs / GT) * SSTEP);
        end
`endif
      end
    end
    if (chk) begin
      exp_rgb.push_back(er);
      exp_srv.push_back(es);
    end
    @(posedge clk);
    if (rst) begin
      t_m = 0; c_m = 0; mode_m = 0;
    end else begin
      t_m++;
      if (md != mode_m) begin mode_m = md; c_m = 0; end
      else c_m++;
    end
    #1;
    if (chk) begin
      er = exp_rgb.pop_front();
      es = exp_srv.pop_front();
      vectors += 2;
      assert (rgb === er) else begin
        miscompares++;
        $error("FAIL rgb sw=%b t=%0d c=%0d got %b want %b", sw, t_m, c_m, rgb, er);
      end
      assert (servo_out === es) else begin
        miscompares++;
        $error("FAIL servo sw=%b t=%0d c=%0d got %b want %b", sw, t_m, c_m, servo_out, es);
      end
    end
  endtask

  task automatic run(int k);
    repeat (k) step();
  endtask

  initial begin
    rst = 1'b1;
    sw  = 4'b0000;
    run(2);                      // reset state
    rst = 1'b0;
    run(200);                    // all off
    sw = 4'b0001; run(600);      // red breathe, several peaks
    sw = 4'b0010; run(300);      // switch to green, ramp restarts
    rst = 1'b1; run(1);          // mid-operation reset
    rst = 1'b0; run(200);
    sw = 4'b0100; run(1000);     // full colour wheel, all six phases
    sw = 4'b1000; run(700);      // servo frames
    sw = 4'b0110; run(150);      // priority: green wins
    sw = 4'b1100; run(120);      // priority: wheel wins
    sw = 4'b1001; run(120);      // priority: red wins over servo
    sw = 4'b0000; run(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
